// File: rtl/ir_cmd_decoder_if.sv
// IR command decoder bus: raw NEC frame in, decoded selection out.
// master drives code_in; slave is the decoder.
interface ir_cmd_decoder_if;
  logic [31:0] code_in;
  logic        cmd_valid;
  logic [7:0]  cmd_key;
  logic [2:0]  button;
  logic [1:0]  color_mode;
  logic        overwrite;
  logic [7:0]  err_count;

  modport master (
    output code_in,
    input  cmd_valid, cmd_key, button,
    input  color_mode, overwrite, err_count
  );

  modport slave (
    input  code_in,
    output cmd_valid, cmd_key, button,
    output color_mode, overwrite, err_count
  );
endinterface

// File: rtl/ir_cmd_decoder.sv
// NEC IR command qualifier/decoder with timed selection hold.
// Define IR_ERR_CNT_EN to build the saturating malformed-frame counter.
module ir_cmd_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic [31:0] HOLD_CYCLES   = 32'd250_000_000
) (
  input  logic            clk,
  input  logic            reset,
  ir_cmd_decoder_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_QUAL   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam logic [15:0] STABLE_LAST =
    16'(STABLE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST =
    HOLD_CYCLES - 32'd1;

  logic [1:0]  state_q, state_d;
  logic [31:0] code_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        sel_q, sel_d;
  logic        pend_q, pend_d;
  logic [7:0]  pkey_q, pkey_d;
  logic        valid_q, valid_d;
  logic [7:0]  key_q, key_d;
  logic [2:0]  btn_q, btn_d;
  logic [1:0]  col_q, col_d;

  logic       change;
  logic       nonzero;
  logic       frame_ok;
  logic       expire;
  logic       qual_done;
  logic [1:0] rest_st;

  assign change    = bus.code_in != code_q;
  assign nonzero   = bus.code_in != 32'd0;
  assign frame_ok  =
    bus.code_in[31:24] == ~bus.code_in[23:16];
  assign expire    = sel_q && (hold_q == 32'd0);
  assign qual_done = !change && (cnt_q == STABLE_LAST);
  // Where QUAL falls back to when it gives up
  assign rest_st   =
    (sel_q && !expire) ? S_ACTIVE : S_IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    pkey_d  = pkey_q;
    unique case (state_q)
      S_IDLE: begin
        if (change && nonzero) begin
          state_d = S_QUAL;
          cnt_d   = 16'd0;
        end
      end
      S_QUAL: begin
        if (change) begin
          cnt_d = 16'd0;
          if (!nonzero) state_d = rest_st;
        end else if (qual_done) begin
          if (frame_ok) begin
            pend_d  = 1'b1;
            pkey_d  = bus.code_in[23:16];
            state_d = S_ACTIVE;
          end else begin
            state_d = rest_st;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACTIVE: begin
        if (change && nonzero) begin
          state_d = S_QUAL;
          cnt_d   = 16'd0;
        end else if (expire && !pend_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Acceptance takes priority over a coincident expiry
  always_comb begin
    valid_d = 1'b0;
    key_d   = key_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    btn_d   = btn_q;
    col_d   = col_q;
    if (pend_q) begin
      valid_d = 1'b1;
      key_d   = pkey_q;
      sel_d   = 1'b1;
      hold_d  = HOLD_LAST;
      unique case (1'b1)
        (pkey_q == 8'h01): begin
          btn_d = 3'b001;
          col_d = 2'b00;
        end
        (pkey_q == 8'h02): begin
          btn_d = 3'b010;
          col_d = 2'b01;
        end
        (pkey_q == 8'h03): begin
          btn_d = 3'b100;
          col_d = 2'b10;
        end
        default: begin
          btn_d = 3'b000;
          col_d = 2'b00;
        end
      endcase
    end else if (expire) begin
      sel_d = 1'b0;
      btn_d = 3'b000;
      col_d = 2'b00;
    end else if (sel_q) begin
      hold_d = hold_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= 32'd0;
      cnt_q   <= 16'd0;
      hold_q  <= 32'd0;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      pkey_q  <= 8'h00;
      valid_q <= 1'b0;
      key_q   <= 8'h00;
      btn_q   <= 3'b000;
      col_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      code_q  <= bus.code_in;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      pkey_q  <= pkey_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      btn_q   <= btn_d;
      col_q   <= col_d;
    end
  end

  assign bus.cmd_valid  = valid_q;
  assign bus.cmd_key    = key_q;
  assign bus.button     = btn_q;
  assign bus.color_mode = col_q;
  assign bus.overwrite  = sel_q;

`ifdef IR_ERR_CNT_EN
  logic [7:0] err_q, err_d;
  logic       err_inc;

  assign err_inc =
    (state_q == S_QUAL) && qual_done && !frame_ok;

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF))
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 8'h00;
    else       err_q <= err_d;
  end

  assign bus.err_count = err_q;
`else
  assign bus.err_count = 8'h00;
`endif
endmodule
